// File: rtl/jk_ff_bank.sv
// -----------------------------------------------------------------------------
// jk_ff_bank
//
// Bank of CHANNELS JK cells sharing one falling-edge clock (CPN). Each cell has
// its own synchronous active-low preset (SDN) and clear (CDN). A mode input
// selects how the bank's next state is formed:
//   MODE 00 : independent JK flip-flops (hold / reset / set / toggle)
//   MODE 01 : synchronous binary up-counter, gated by EN
//   MODE 10 : shift register toward the MSB, SI entering bit 0, gated by EN
//   MODE 11 : hold
// Preset beats clear, and both beat the mode function, in every mode.
//
// Parameters
//   CHANNELS  : number of cells (1..32), bit 0 is the LSB
//   RESET_VAL : value forced into Q while RDN is low (upper bits truncated)
//
// Ports
//   CPN   in   1         clock, all state changes on the falling edge
//   RDN   in   1         asynchronous active-low reset of the whole bank
//   MODE  in   2         function select (see above)
//   EN    in   1         enable for COUNT and SHIFT, ignored otherwise
//   J, K  in   CHANNELS  per-cell JK inputs (used in MODE 00 only)
//   SI    in   1         serial input for SHIFT
//   SDN   in   CHANNELS  per-cell synchronous preset, active-low
//   CDN   in   CHANNELS  per-cell synchronous clear, active-low
//   Q     out  CHANNELS  cell state
//   QN    out  CHANNELS  complement of Q
//   TC    out  1         terminal count: COUNT mode, EN high, Q all ones
//   SO    out  1         serial out, Q[CHANNELS-1]
//
// Build option
//   HC112_COMPAT_EN : when defined, a cell whose SDN and CDN are both low at
//   an edge shows Q=1 and QN=1 (the 74HC112 both-high condition) until an
//   edge where either is released. When undefined, preset simply wins and QN
//   is always ~Q.
// -----------------------------------------------------------------------------
module jk_ff_bank #(
  parameter int          CHANNELS  = 8,
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  logic                CPN,
  input  logic                RDN,
  input  logic [1:0]          MODE,
  input  logic                EN,
  input  logic [CHANNELS-1:0] J,
  input  logic [CHANNELS-1:0] K,
  input  logic                SI,
  input  logic [CHANNELS-1:0] SDN,
  input  logic [CHANNELS-1:0] CDN,
  output logic [CHANNELS-1:0] Q,
  output logic [CHANNELS-1:0] QN,
  output logic                TC,
  output logic                SO
);

  localparam logic [CHANNELS-1:0] LP_RST_Q = RESET_VAL[CHANNELS-1:0];

  localparam logic [1:0] MODE_JK    = 2'b00;
  localparam logic [1:0] MODE_COUNT = 2'b01;
  localparam logic [1:0] MODE_SHIFT = 2'b10;
  localparam logic [1:0] MODE_HOLD  = 2'b11;

  // Characteristic equation of a JK cell, applied bitwise so that an unknown
  // J or K on one channel only disturbs that channel.
  function automatic logic [CHANNELS-1:0] jk_next(
    input logic [CHANNELS-1:0] q,
    input logic [CHANNELS-1:0] j,
    input logic [CHANNELS-1:0] k
  );
    jk_next = (j & ~q) | (~k & q);
  endfunction

  // Preset dominates clear, clear dominates the mode result.
  function automatic logic [CHANNELS-1:0] apply_set_clr(
    input logic [CHANNELS-1:0] mode_q,
    input logic [CHANNELS-1:0] sdn,
    input logic [CHANNELS-1:0] cdn
  );
    apply_set_clr = ~sdn | (cdn & mode_q);
  endfunction

  logic [CHANNELS-1:0] r_q;
  logic [CHANNELS-1:0] w_inc;
  logic [CHANNELS:0]   w_shift_ext;
  logic [CHANNELS-1:0] w_shift;
  logic [CHANNELS-1:0] w_mode_q;
  logic [CHANNELS-1:0] w_q_next;

  assign w_inc = r_q + CHANNELS'(1);

  // Appending SI below Q and dropping the top bit covers CHANNELS==1 too,
  // where the result is just SI.
  assign w_shift_ext = {r_q, SI};
  assign w_shift     = w_shift_ext[CHANNELS-1:0];

  always_comb begin
    w_mode_q = r_q;
    case (MODE)
      MODE_JK:    w_mode_q = jk_next(r_q, J, K);
      MODE_COUNT: w_mode_q = EN ? w_inc : r_q;
      MODE_SHIFT: w_mode_q = EN ? w_shift : r_q;
      MODE_HOLD:  w_mode_q = r_q;
      default:    w_mode_q = r_q;
    endcase
  end

  assign w_q_next = apply_set_clr(w_mode_q, SDN, CDN);

  always_ff @(negedge CPN or negedge RDN) begin
    if (!RDN) begin
      r_q <= LP_RST_Q;
    end else begin
      r_q <= w_q_next;
    end
  end

`ifdef HC112_COMPAT_EN
  // Remembers that both preset and clear were low at the last edge; while
  // set, the complement output is forced high alongside Q.
  logic [CHANNELS-1:0] r_qn_force;

  always_ff @(negedge CPN or negedge RDN) begin
    if (!RDN) begin
      r_qn_force <= '0;
    end else begin
      r_qn_force <= ~SDN & ~CDN;
    end
  end

  assign QN = ~r_q | r_qn_force;
`else
  assign QN = ~r_q;
`endif

  assign Q  = r_q;
  assign TC = (MODE == MODE_COUNT) && EN && (&r_q);
  assign SO = r_q[CHANNELS-1];

endmodule

// File: tb/tb_jk_ff_bank.sv
// -----------------------------------------------------------------------------
// tb_jk_ff_bank
//
// Drives an 8-channel bank (RESET_VAL = 8'h5A) through directed scenarios and
// a randomized run. A reference model, built from the behavioural rules
// (integer add for COUNT, shift-and-or for SHIFT, a JK truth table per bit,
// then preset/clear per bit), predicts Q/QN/TC/SO after every falling edge.
// Inputs change 1 time unit after a falling edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_jk_ff_bank;

  localparam int N = 8;

  logic         CPN;
  logic         RDN;
  logic [1:0]   MODE;
  logic         EN;
  logic [N-1:0] J;
  logic [N-1:0] K;
  logic         SI;
  logic [N-1:0] SDN;
  logic [N-1:0] CDN;
  logic [N-1:0] Q;
  logic [N-1:0] QN;
  logic         TC;
  logic         SO;

  int checks;
  int errors;

  logic [N-1:0] m_q;
  logic [N-1:0] m_force;

  jk_ff_bank #(
    .CHANNELS (N),
    .RESET_VAL(32'h5A)
  ) dut (
    .CPN (CPN),
    .RDN (RDN),
    .MODE(MODE),
    .EN  (EN),
    .J   (J),
    .K   (K),
    .SI  (SI),
    .SDN (SDN),
    .CDN (CDN),
    .Q   (Q),
    .QN  (QN),
    .TC  (TC),
    .SO  (SO)
  );

  initial begin
    CPN = 1'b1;
    forever #5 CPN = ~CPN;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] exp_qn();
`ifdef HC112_COMPAT_EN
    return ~m_q | m_force;
`else
    return ~m_q;
`endif
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".Q"}, 32'(Q), 32'(m_q));
    chk({tag, ".QN"}, 32'(QN), 32'(exp_qn()));
    chk({tag, ".TC"}, 32'(TC), 32'((MODE == 2'd1 && EN == 1'b1 && m_q == 8'hFF) ? 1 : 0));
    chk({tag, ".SO"}, 32'(SO), 32'(m_q[N-1]));
  endtask

  // Predict the next state from the current inputs, take one falling edge,
  // then compare.
  task automatic step(input string tag);
    int unsigned nq;
    logic [N-1:0] b;
    nq = m_q;
    case (MODE)
      2'd0: begin
        b = m_q;
        for (int i = 0; i < N; i++) begin
          case ({J[i], K[i]})
            2'b01:   b[i] = 1'b0;
            2'b10:   b[i] = 1'b1;
            2'b11:   b[i] = ~m_q[i];
            default: b[i] = m_q[i];
          endcase
        end
        nq = b;
      end
      2'd1: if (EN) nq = (m_q + 1) % 256;
      2'd2: if (EN) nq = ((m_q * 2) % 256) + SI;
      default: nq = m_q;
    endcase
    b = nq[N-1:0];
    for (int i = 0; i < N; i++) begin
      m_force[i] = (!SDN[i] && !CDN[i]);
      if (!SDN[i])      b[i] = 1'b1;
      else if (!CDN[i]) b[i] = 1'b0;
    end
    m_q = b;
    @(negedge CPN);
    #1;
    check_all(tag);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    m_force = '0;
    m_q     = '0;
    RDN  = 1'b1;
    MODE = 2'b11;
    EN   = 1'b0;
    J    = '0;
    K    = '0;
    SI   = 1'b0;
    SDN  = '1;
    CDN  = '1;

    // Reset asserted while CPN is high, checked before any falling edge.
    @(posedge CPN);
    #2;
    RDN = 1'b0;
    #1;
    m_q = 8'h5A;
    m_force = '0;
    chk("rst.Q", 32'(Q), 32'h5A);
    chk("rst.QN", 32'(QN), 32'hA5);
    @(negedge CPN);
    #1;
    chk("rst_edge.Q", 32'(Q), 32'h5A);
    RDN = 1'b1;
    MODE = 2'b11;
    step("hold0");
    chk("hold0.lit", 32'(Q), 32'h5A);
    step("hold1");

    // JK: clear, then set/reset pattern, then toggle all.
    CDN = 8'h00;
    step("jk_clr");
    CDN = '1;
    MODE = 2'b00;
    J = 8'hF0; K = 8'h0F;
    step("jk1");
    chk("jk1.lit", 32'(Q), 32'hF0);
    J = 8'hFF; K = 8'hFF;
    step("jk2");
    chk("jk2.lit", 32'(Q), 32'h0F);
    J = 8'h00; K = 8'h00;
    step("jk_hold");

    // COUNT wrap from 8'hFE.
    MODE = 2'b11;
    SDN = 8'h01; CDN = 8'hFE;
    step("cnt_load");
    SDN = '1; CDN = '1;
    MODE = 2'b01; EN = 1'b1;
    #1;
    chk("cnt_fe.TC", 32'(TC), 32'h0);
    step("cnt1");
    chk("cnt1.lit", 32'(Q), 32'hFF);
    chk("cnt1.TC", 32'(TC), 32'h1);
    step("cnt2");
    chk("cnt2.lit", 32'(Q), 32'h00);
    chk("cnt2.TC", 32'(TC), 32'h0);
    EN = 1'b0;
    for (int i = 0; i < 3; i++) step("cnt_hold");
    chk("cnt_hold.lit", 32'(Q), 32'h00);

    // SHIFT: 1,0,1,1 then four ones.
    MODE = 2'b10; EN = 1'b1;
    SI = 1'b1; step("sh");
    SI = 1'b0; step("sh");
    SI = 1'b1; step("sh");
    SI = 1'b1; step("sh");
    chk("sh4.lit", 32'(Q), 32'h0B);
    chk("sh4.SO", 32'(SO), 32'h0);
    for (int i = 0; i < 4; i++) step("sh");
    chk("sh8.lit", 32'(Q), 32'hBF);
    chk("sh8.SO", 32'(SO), 32'h1);
    EN = 1'b0; SI = 1'b0;
    step("sh_hold");

    // Preset/clear priority over COUNT.
    MODE = 2'b11;
    SDN = 8'hF0; CDN = 8'h0F;
    step("pri_load");
    MODE = 2'b01; EN = 1'b1;
    SDN = 8'h7F; CDN = 8'hFE;
    step("pri");
    chk("pri.lit", 32'(Q), 32'h90);

    // Preset and clear together on channel 3.
    MODE = 2'b11; EN = 1'b0;
    SDN = 8'hF7; CDN = 8'hF7;
    step("both");
    chk("both.Q3", 32'(Q[3]), 32'h1);
`ifdef HC112_COMPAT_EN
    chk("both.QN3", 32'(QN[3]), 32'h1);
`else
    chk("both.QN3", 32'(QN[3]), 32'h0);
`endif
    SDN = '1; CDN = '1;
    step("both_rel");
    chk("both_rel.QN3", 32'(QN[3]), 32'h0);

    // Randomized run; preset/clear are sparse so modes get exercised.
    for (int n = 0; n < 300; n++) begin
      MODE = 2'($urandom_range(0, 3));
      EN   = 1'($urandom_range(0, 3) != 0);
      J    = 8'($urandom);
      K    = 8'($urandom);
      SI   = 1'($urandom);
      SDN  = ~(8'($urandom) & 8'($urandom) & 8'($urandom));
      CDN  = ~(8'($urandom) & 8'($urandom) & 8'($urandom));
      step("rnd");
    end

    // Asynchronous reset in the middle of activity.
    @(posedge CPN);
    #1;
    RDN = 1'b0;
    #1;
    m_q = 8'h5A;
    m_force = '0;
    chk("rst2.Q", 32'(Q), 32'h5A);
    chk("rst2.QN", 32'(QN), 32'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_ff_bank.md
Name: jk_ff_bank

Overview:
- Parametrised successor to the dual negative-edge JK flip-flop: CHANNELS JK cells sharing one falling-edge clock, with per-channel preset/clear.
- Adds mode control so the same cells operate as independent JK flip-flops, a synchronous binary counter, a shift register, or hold.
- Sits beside the discrete-logic models as a drop-in register bank for small counter and sequencer datapaths.

Parameters:
CHANNELS, 8, number of JK cells (1..32); bit 0 is LSB.
RESET_VAL, 0, value loaded into Q on RDN assertion (CHANNELS bits, upper bits truncated).

Ports:
CPN  input  1  clock; all state changes on falling edge.
RDN  input  1  asynchronous active-low reset for all channels.
MODE  input  2  00=JK, 01=COUNT, 10=SHIFT, 11=HOLD.
EN  input  1  active-high enable for COUNT and SHIFT; ignored in JK and HOLD.
J  input  CHANNELS  per-channel J.
K  input  CHANNELS  per-channel K.
SI  input  1  serial input for SHIFT mode.
SDN  input  CHANNELS  per-channel synchronous preset, active-low.
CDN  input  CHANNELS  per-channel synchronous clear, active-low.
Q  output  CHANNELS  cell state.
QN  output  CHANNELS  complement outputs.
TC  output  1  terminal count: high when MODE==01, EN==1, Q all ones.
SO  output  1  serial out = Q[CHANNELS-1].

Behaviour:
- Clock is CPN, falling-edge triggered; reset is asynchronous, active-low (RDN). RDN low forces Q=RESET_VAL, QN=~RESET_VAL immediately, regardless of CPN. Release is synchronous to the next falling edge: first update occurs on the first falling edge with RDN high.
- Per-channel priority at each falling edge, highest first: SDN[i]==0 -> Q[i]=1; CDN[i]==0 -> Q[i]=0; otherwise mode function. Preset/clear apply in every mode, including HOLD.
- JK (00): per channel: J=0,K=0 hold; J=0,K=1 Q=0; J=1,K=0 Q=1; J=1,K=1 toggle.
- COUNT (01): EN=1 -> Q = Q+1 modulo 2^CHANNELS; wrap all-ones -> 0. EN=0 -> hold. J/K ignored. Channels under preset/clear take that value; remaining channels take their bit of Q+1 (computed from pre-edge Q).
- SHIFT (10): EN=1 -> Q = {Q[CHANNELS-2:0], SI}; CHANNELS==1 -> Q[0]=SI. EN=0 -> hold.
- HOLD (11): Q unchanged except preset/clear.
- MODE change takes effect on the next falling edge; no pipeline, latency 1 edge for all functions.
- QN = ~Q (see Optional Feature for the exception).
- TC combinational from registered Q, MODE, EN; SO combinational from Q.
- No X propagation masking: X on J/K of a channel affects only that channel.

Optional Feature:
- Macro HC112_COMPAT_EN.
- Defined: per-channel SDN[i]==0 and CDN[i]==0 at the same edge -> Q[i]=1 and QN[i]=1 (both-high 74HC112 condition), held until the next edge where either is released; then QN[i] returns to ~Q[i], Q[i] computed normally from Q[i]=1.
- Undefined: preset wins, Q[i]=1, QN[i]=0; QN always ~Q. The extra per-channel forced-QN flag is not built.

Test Plan:
- Reset: CHANNELS=8, RESET_VAL=8'h5A, RDN low mid-cycle with CPN high -> Q=8'h5A, QN=8'hA5 before any edge; release, MODE=11 -> Q stays 8'h5A.
- JK: MODE=00, Q=8'h00, J=8'hF0, K=8'h0F then J=K=8'hFF -> Q=8'hF0 after edge 1, 8'h0F after edge 2.
- COUNT wrap: MODE=01, EN=1, Q preset to 8'hFE -> TC low, edge -> 8'hFF, TC high, edge -> 8'h00, TC low; EN=0 for 3 edges -> Q stays 8'h00.
- SHIFT: MODE=10, EN=1, Q=8'h00, SI=1,0,1,1 over 4 edges -> Q=8'h0B, SO=0; 4 more edges with SI=1 -> Q=8'hBF, SO=1.
- Priority: MODE=01, Q=8'h0F, SDN=8'h7F, CDN=8'hFE -> next Q=8'h90 (bit7 preset, bit0 clear, others from 8'h10).
- Compat: SDN[3]=CDN[3]=0 -> with HC112_COMPAT_EN Q[3]=1,QN[3]=1; without, Q[3]=1,QN[3]=0.
